clk_div_mgr: RTL and testbench
==============================

Name: clk_div_mgr

Overview:
- Parametrised N-channel clock-divider manager, successor to the fixed two-output PLL wrapper.
- Takes the PLL output clock and generates per-channel divided clocks, clock-enable strobes and per-channel synchronous reset releases.
- Divide ratios are programmable at runtime through a valid/ready config port; ratio changes apply glitch-free at period boundaries.
- Includes a startup/lock sequencer, so downstream logic sees a single "locked" indication.

Parameters:
- NUM_CH, 2, number of output channels (1..8)
- CH_W, 1, width of cfg_ch (>= clog2(NUM_CH), minimum 1)
- DIV_W, 8, width of divide and phase values
- DEF_DIV, 4, divide ratio loaded into every channel at reset
- LOCK_CYCLES, 16, cycles spent in WAIT before RUN (>= 1)

Ports:
- clk  in  1  PLL output clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 starts the sequencer, 0 returns to IDLE
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
- cfg_ch  in  CH_W  target channel
- cfg_div  in  DIV_W  new divide ratio D
- cfg_phase  in  DIV_W  start phase offset P
- clk_out  out  NUM_CH  divided clocks, flop outputs
- ce_out  out  NUM_CH  1-cycle strobe at each clk_out rising edge
- ch_rst_n  out  NUM_CH  per-channel reset, active low
- locked  out  1  high while sequencer is in RUN

Behaviour:
- Reset values: clk_out=0, ce_out=0, ch_rst_n=0, locked=0, cfg_ready=1. Every channel div=DEF_DIV, phase=0, cnt=0. FSM in IDLE.
- FSM transitions:
  - IDLE -> WAIT when enable=1; lock counter cleared.
  - WAIT -> RUN after LOCK_CYCLES cycles in WAIT.
  - Any state -> IDLE on the cycle after enable=0.
- locked=1 exactly while in RUN. locked rises LOCK_CYCLES+1 cycles after the first enable=1 sample.
- Channel counter cnt runs only in RUN; it is held at 0 elsewhere. In IDLE/WAIT, clk_out, ce_out and ch_rst_n are all 0.
- On RUN entry, each channel loads cnt=(D-P) mod D. P>=D is treated as P=0.
- Counting: cnt increments each cycle and wraps from D-1 to 0.
- Outputs are registered from the next-count value, so they are flop outputs aligned with cnt (no decode glitches):
  - ce_out[i]=1 iff cnt==0.
  - clk_out[i]=1 iff cnt<floor(D/2). High time is floor(D/2), low time is D-floor(D/2); for example D=5 gives 2 high, 3 low.
- D=0 or D=1 means bypass: ce_out constant 1 in RUN, clk_out held 0.
- With P=0, ce_out is high in the first RUN cycle. All channels with equal D and P are edge-aligned.
- ch_rst_n[i] goes 1 on the first ce_out[i] pulse in RUN (same cycle). It returns to 0 on the cycle after leaving RUN.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready; cfg_ch, cfg_div and cfg_phase are captured as pending and cfg_ready drops to 0.
  - In IDLE/WAIT the pending update applies on the next cycle; cfg_ready returns to 1 one cycle after the transfer.
  - In RUN, the new D applies at the target channel's wrap: cycle with cnt==D_old-1 -> next cnt=0 with D_new. The current period completes with no runt pulse. cfg_ready returns to 1 the cycle after the apply.
  - In RUN, phase is stored and used only on the next RUN entry.
  - cfg_ch>=NUM_CH: transfer accepted and discarded; cfg_ready returns to 1 the next cycle.
- Pending update when enable drops: applied immediately on IDLE entry.
- Asynchronous reset mid-operation: all state returns to reset values, including the D register and any pending config.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined: adds output cfg_rdata [DIV_W]. It shows the active D of channel cfg_ch, registered with 1-cycle latency, and reads 0 for cfg_ch>=NUM_CH.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults (NUM_CH=2, DEF_DIV=4, LOCK_CYCLES=16), enable=1 at cycle 0 -> locked=1 at cycle 17; ce_out[0] pulses every 4 cycles; clk_out[0] 2 high / 2 low; ch_rst_n[0] rises with the first ce_out.
- In IDLE, program ch0 D=42 and ch1 D=84, then enable -> ch0 period 42 (21/21), ch1 period 84 (42/42); every ch1 ce_out coincides with every second ch0 ce_out.
- ch0 D=5 -> clk_out 2 high / 3 low; ce_out every 5 cycles. ch1 D=1 -> ce_out[1] constant 1, clk_out[1]=0.
- RUN with ch0 D=4, write D=6 when cnt=1 -> two more cycles of the old period, then period 6; cfg_ready low until one cycle after the apply.
- Both channels D=8, ch1 P=3 -> first ce_out[1] 3 cycles after first ce_out[0], then fixed 3-cycle skew; P=9 behaves as P=0.
- enable=0 mid-RUN -> next cycle locked=0, clk_out/ce_out/ch_rst_n=0. Re-enable -> relock after 16 cycles. rst_n pulse mid-RUN -> D back to 4, cfg_ready=1.

Source files
------------

// File: rtl/clk_div_mgr.sv
// N-channel clock-divider manager: lock sequencer plus runtime-programmable,
// glitch-free per-channel dividers. Optional macro CFG_READBACK_EN adds cfg_rdata.
module clk_div_mgr #(
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 1,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
`ifdef CFG_READBACK_EN
  output logic [DIV_W-1:0]  cfg_rdata,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam int CHX = CH_W + 1;
  localparam logic [CHX-1:0] NUM_CH_X = CHX'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [LCW-1:0]   lock_cnt_q;
  logic             locked_q;

  logic             pend_q;
  logic             ready_q;
  logic [CH_W-1:0]  pend_ch_q;
  logic [DIV_W-1:0] pend_div_q;
  logic [DIV_W-1:0] pend_phase_q;

  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] phase_d [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] clk_q, ce_q, rst_q;
  logic [NUM_CH-1:0] clk_d, ce_d, rst_d;
  logic [NUM_CH-1:0] wrap_s, apply_ch_s;

  logic run_entry_s, run_next_s, cfg_fire_s, pend_ok_s, apply_s;

  // Sequencer look-ahead: whether the next cycle is a RUN cycle.
  always_comb begin
    run_entry_s = (state_q == ST_WAIT) && enable && (lock_cnt_q == LOCK_LAST);
    run_next_s  = enable && ((state_q == ST_RUN) || run_entry_s);
    cfg_fire_s  = cfg_valid && ready_q;
    pend_ok_s   = ({1'b0, pend_ch_q} < NUM_CH_X);
  end

  // Startup/lock sequencer with registered lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q    <= ST_WAIT;
            lock_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_q <= ST_RUN;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCW'(1);
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      locked_q <= run_next_s;
    end
  end

  // Per-channel next count; a pending ratio only lands on its channel's wrap
  // while running, so the current period always completes.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrap_s[i]     = (div_q[i] <= DIV_W'(1)) || (cnt_q[i] == div_q[i] - DIV_W'(1));
      apply_ch_s[i] = pend_q && pend_ok_s && (pend_ch_q == CH_W'(i)) &&
                      ((state_q != ST_RUN) || !enable || wrap_s[i]);
      div_d[i]      = apply_ch_s[i] ? pend_div_q   : div_q[i];
      phase_d[i]    = apply_ch_s[i] ? pend_phase_q : phase_q[i];
      if (!run_next_s) begin
        cnt_d[i] = '0;
      end else if (run_entry_s) begin
        if ((div_d[i] <= DIV_W'(1)) || (phase_d[i] == '0) || (phase_d[i] >= div_d[i])) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = div_d[i] - phase_d[i];
        end
      end else if (wrap_s[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
      ce_d[i]  = run_next_s && (cnt_d[i] == '0);
      clk_d[i] = run_next_s && (div_d[i] >= DIV_W'(2)) && (cnt_d[i] < (div_d[i] >> 1));
      rst_d[i] = run_next_s && (rst_q[i] || ce_d[i]);
    end
    apply_s = pend_q && (!pend_ok_s || (|apply_ch_s));
  end

  // Channel state and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(DEF_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      clk_q <= '0;
      ce_q  <= '0;
      rst_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clk_q <= clk_d;
      ce_q  <= ce_d;
      rst_q <= rst_d;
    end
  end

  // Single-entry config holding register; ready stays low until it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      ready_q      <= 1'b1;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
    end else if (cfg_fire_s) begin
      pend_q       <= 1'b1;
      ready_q      <= 1'b0;
      pend_ch_q    <= cfg_ch;
      pend_div_q   <= cfg_div;
      pend_phase_q <= cfg_phase;
    end else if (apply_s) begin
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      pend_q  <= pend_q;
      ready_q <= ready_q;
    end
  end

`ifdef CFG_READBACK_EN
  logic [DIV_W-1:0] rd_s;
  logic [DIV_W-1:0] rdata_q;

  // Active-ratio lookup for the addressed channel; unknown channels read 0.
  always_comb begin
    rd_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        rd_s = div_q[i];
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // One-cycle registered readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_s;
    end
  end

  assign cfg_rdata = rdata_q;
`endif

  assign cfg_ready = ready_q;
  assign clk_out   = clk_q;
  assign ce_out    = ce_q;
  assign ch_rst_n  = rst_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clk_div_mgr.sv
// Directed self-checking bench for clk_div_mgr at default parameters.
module tb_clk_div_mgr;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] ce_out;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              locked;
`ifdef CFG_READBACK_EN
  logic [DIV_W-1:0]  cfg_rdata;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clk_div_mgr #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEF_DIV(4), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase),
`ifdef CFG_READBACK_EN
    .cfg_rdata(cfg_rdata),
`endif
    .clk_out(clk_out), .ce_out(ce_out), .ch_rst_n(ch_rst_n), .locked(locked)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // IDLE-only write: transfer cycle, then one cycle for the apply.
  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv,
                           input logic [DIV_W-1:0] ph);
    cfg_ch = ch; cfg_div = dv; cfg_phase = ph; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    step(2);
    n_tests++;
    if ({locked, cfg_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_lock_ready: got %b expected 01", {locked, cfg_ready});
    end
    n_tests++;
    if ({clk_out, ce_out, ch_rst_n} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b expected 000000", {clk_out, ce_out, ch_rst_n});
    end
    rst_n = 1'b1;
    step(2);
    n_tests++;
    if ({locked, cfg_ready, ce_out} !== 4'b0100) begin
      n_fail++; $display("FAIL idle_hold: got %b expected 0100", {locked, cfg_ready, ce_out});
    end
  endtask

  task automatic test_lock;
    logic [1:0] exp_v;
    enable = 1'b1;
    step(16);
    n_tests++;
    if ({locked, ce_out, ch_rst_n} !== 5'b0) begin
      n_fail++; $display("FAIL lock_wait: got %b expected 00000", {locked, ce_out, ch_rst_n});
    end
    step(1);
    n_tests++;
    if ({locked, clk_out, ce_out, ch_rst_n} !== 7'b1111111) begin
      n_fail++; $display("FAIL lock_entry: got %b expected 1111111", {locked, clk_out, ce_out, ch_rst_n});
    end
    for (int t = 1; t <= 12; t++) begin
      step(1);
      exp_v = {(t % 4) < 2, (t % 4) == 0};
      n_tests++;
      if ({clk_out[0], ce_out[0]} !== exp_v || ch_rst_n[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_div4 t=%0d: got clk/ce %b rst %b expected %b rst 1",
                 t, {clk_out[0], ce_out[0]}, ch_rst_n[0], exp_v);
      end
    end
  endtask

  task automatic test_div_42_84;
    logic [3:0] exp_v;
    enable = 1'b0;
    step(1);
    n_tests++;
    if ({locked, clk_out, ce_out, ch_rst_n} !== 7'b0) begin
      n_fail++; $display("FAIL disable_outs: got %b expected 0000000", {locked, clk_out, ce_out, ch_rst_n});
    end
    cfg_ch = 1'b0; cfg_div = 8'd42; cfg_phase = 8'd0; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    n_tests++;
    if (cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready_low: got %b expected 0", cfg_ready);
    end
    step(1);
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready_back: got %b expected 1", cfg_ready);
    end
    cfg_write(1'b1, 8'd84, 8'd0);
    enable = 1'b1;
    step(17);
    for (int t = 0; t < 168; t++) begin
      if (t > 0) step(1);
      exp_v = {(t % 84) < 42, (t % 42) < 21, (t % 84) == 0, (t % 42) == 0};
      n_tests++;
      if ({clk_out, ce_out} !== exp_v) begin
        n_fail++; $display("FAIL div42_84 t=%0d: got %b expected %b", t, {clk_out, ce_out}, exp_v);
      end
    end
  endtask

  task automatic test_odd_bypass;
    logic [3:0] exp_v;
    enable = 1'b0;
    step(1);
    cfg_write(1'b0, 8'd5, 8'd0);
    cfg_write(1'b1, 8'd1, 8'd0);
    enable = 1'b1;
    step(17);
    n_tests++;
    if (ch_rst_n !== 2'b11) begin
      n_fail++; $display("FAIL odd_rst: got %b expected 11", ch_rst_n);
    end
    for (int t = 0; t < 15; t++) begin
      if (t > 0) step(1);
      exp_v = {1'b0, (t % 5) < 2, 1'b1, (t % 5) == 0};
      n_tests++;
      if ({clk_out, ce_out} !== exp_v) begin
        n_fail++; $display("FAIL div5_bypass t=%0d: got %b expected %b", t, {clk_out, ce_out}, exp_v);
      end
    end
  endtask

  task automatic test_runtime_change;
    logic [1:0] exp_v;
    enable = 1'b0;
    step(1);
    cfg_write(1'b0, 8'd4, 8'd0);
    enable = 1'b1;
    step(18);
    n_tests++;
    if ({cfg_ready, clk_out[0], ce_out[0]} !== 3'b110) begin
      n_fail++; $display("FAIL rt_cnt1: got %b expected 110", {cfg_ready, clk_out[0], ce_out[0]});
    end
    cfg_ch = 1'b0; cfg_div = 8'd6; cfg_phase = 8'd0; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    n_tests++;
    if ({cfg_ready, clk_out[0], ce_out[0]} !== 3'b000) begin
      n_fail++; $display("FAIL rt_cnt2: got %b expected 000", {cfg_ready, clk_out[0], ce_out[0]});
    end
    step(1);
    n_tests++;
    if ({cfg_ready, clk_out[0], ce_out[0]} !== 3'b000) begin
      n_fail++; $display("FAIL rt_cnt3: got %b expected 000", {cfg_ready, clk_out[0], ce_out[0]});
    end
    step(1);
    n_tests++;
    if ({cfg_ready, clk_out[0], ce_out[0]} !== 3'b111) begin
      n_fail++; $display("FAIL rt_apply: got %b expected 111", {cfg_ready, clk_out[0], ce_out[0]});
    end
    for (int t = 1; t <= 12; t++) begin
      step(1);
      exp_v = {(t % 6) < 3, (t % 6) == 0};
      n_tests++;
      if ({clk_out[0], ce_out[0]} !== exp_v) begin
        n_fail++; $display("FAIL rt_div6 t=%0d: got %b expected %b", t, {clk_out[0], ce_out[0]}, exp_v);
      end
    end
  endtask

  task automatic test_phase;
    logic [5:0] exp_v;
    enable = 1'b0;
    step(1);
    cfg_write(1'b0, 8'd8, 8'd0);
    cfg_write(1'b1, 8'd8, 8'd3);
    enable = 1'b1;
    step(17);
    for (int t = 0; t < 24; t++) begin
      if (t > 0) step(1);
      exp_v = {t >= 3, 1'b1, ((t + 5) % 8) < 4, (t % 8) < 4, ((t + 5) % 8) == 0, (t % 8) == 0};
      n_tests++;
      if ({ch_rst_n, clk_out, ce_out} !== exp_v) begin
        n_fail++; $display("FAIL phase3 t=%0d: got %b expected %b", t, {ch_rst_n, clk_out, ce_out}, exp_v);
      end
    end
    enable = 1'b0;
    step(1);
    cfg_write(1'b1, 8'd8, 8'd9);
    enable = 1'b1;
    step(17);
    for (int t = 0; t < 8; t++) begin
      if (t > 0) step(1);
      exp_v = {2'b11, (t % 8) < 4, (t % 8) < 4, (t % 8) == 0, (t % 8) == 0};
      n_tests++;
      if ({ch_rst_n, clk_out, ce_out} !== exp_v) begin
        n_fail++; $display("FAIL phase9 t=%0d: got %b expected %b", t, {ch_rst_n, clk_out, ce_out}, exp_v);
      end
    end
  endtask

  task automatic test_disable_mid_run;
    step(3);
    enable = 1'b0;
    step(1);
    n_tests++;
    if ({locked, clk_out, ce_out, ch_rst_n} !== 7'b0) begin
      n_fail++; $display("FAIL drop_outs: got %b expected 0000000", {locked, clk_out, ce_out, ch_rst_n});
    end
    enable = 1'b1;
    step(16);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL relock_early: got %b expected 0", locked);
    end
    step(1);
    n_tests++;
    if ({locked, ce_out} !== 3'b111) begin
      n_fail++; $display("FAIL relock: got %b expected 111", {locked, ce_out});
    end
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] exp_v;
    step(2);
    cfg_ch = 1'b0; cfg_div = 8'd6; cfg_phase = 8'd0; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    n_tests++;
    if (cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_pending: got %b expected 0", cfg_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cfg_ready, locked, clk_out, ce_out, ch_rst_n} !== 8'b10000000) begin
      n_fail++;
      $display("FAIL async_rst: got %b expected 10000000", {cfg_ready, locked, clk_out, ce_out, ch_rst_n});
    end
    enable = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    enable = 1'b1;
    step(17);
    for (int t = 0; t < 12; t++) begin
      if (t > 0) step(1);
      exp_v = {(t % 4) < 2, (t % 4) < 2, (t % 4) == 0, (t % 4) == 0};
      n_tests++;
      if ({clk_out, ce_out} !== exp_v) begin
        n_fail++; $display("FAIL post_rst_div4 t=%0d: got %b expected %b", t, {clk_out, ce_out}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_div_42_84();
    test_odd_bypass();
    test_runtime_change();
    test_phase();
    test_disable_mid_run();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
